// File: rtl/fpmulr2.sv
// Radix-2 sequential shift-add multiplier: full 2*FPWID product, one multiplier bit per clk4x edge.
// Optional early termination when the remaining multiplier bits are zero: FPMULR2_EARLY_OUT_EN.
module fpmulr2 #(
  parameter int FPWID     = 112,
  parameter int DONE_HOLD = 8
) (
  input  logic                 i_clk4x,
  input  logic                 i_rst_n,
  input  logic                 i_ld,
  input  logic [FPWID-1:0]     i_a,
  input  logic [FPWID-1:0]     i_b,
  output logic [2*FPWID-1:0]   o_p,
  output logic [7:0]           o_lzcnt,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int PW = 2 * FPWID;
  localparam int CW = $clog2(FPWID + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t          r_state;
  logic [FPWID-1:0] r_ma;
  logic [FPWID-1:0] r_mb;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_p;
  logic [7:0]      r_lzcnt;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_hold;
  logic [FPWID:0]  w_sum;

  // Upper half plus the selected partial product; the carry lands in the shifted-in MSB.
  assign w_sum = {1'b0, r_acc[PW-1:FPWID]} + {1'b0, (r_mb[0] ? r_ma : {FPWID{1'b0}})};

  function automatic logic [7:0] clz(input logic [PW-1:0] v);
    logic [7:0] n;
    n = 8'(PW);
    for (int i = 0; i < PW; i++) begin
      if (v[i]) n = 8'(PW - 1 - i);
    end
    return n;
  endfunction

  always_ff @(posedge i_clk4x or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ma    <= '0;
      r_mb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_lzcnt <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hold  <= '0;
    end else if (i_ld) begin
      r_state <= S_RUN;
      r_ma    <= i_a;
      r_mb    <= i_b;
      r_acc   <= '0;
      r_cnt   <= CW'(FPWID);
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
`ifdef FPMULR2_EARLY_OUT_EN
          // No multiplier bits left: the remaining steps are pure right shifts.
          if (r_mb == '0 && r_cnt != '0) begin
            r_acc   <= r_acc >> r_cnt;
            r_cnt   <= '0;
            r_state <= S_FIN;
          end else
`endif
          begin
            r_acc <= {w_sum, r_acc[FPWID-1:1]};
            r_mb  <= r_mb >> 1;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_p     <= r_acc;
          r_lzcnt <= clz(r_acc);
          r_done  <= 1'b1;
          r_hold  <= 8'(DONE_HOLD);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          // Stretch done so the 1x domain is guaranteed to see it.
          if (r_done) begin
            if (r_hold <= 8'd1) begin
              r_done <= 1'b0;
              r_hold <= '0;
            end else begin
              r_hold <= r_hold - 8'd1;
            end
          end
        end
      endcase
    end
  end

  assign o_p     = r_p;
  assign o_lzcnt = r_lzcnt;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

// File: tb/tb_fpmulr2.sv
// Self-checking bench for fpmulr2 at FPWID=8 and FPWID=112 against an a*b reference model.
// Honours FPMULR2_EARLY_OUT_EN when computing the expected latency.
module tb_fpmulr2;

  localparam int HOLD = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ld8, ld112;
  logic [7:0]   a8, b8;
  logic [111:0] a112, b112;
  logic [15:0]  p8;
  logic [223:0] p112;
  logic [7:0]   lz8, lz112;
  logic         busy8, busy112, done8, done112;

  int checks   = 0;
  int failures = 0;
  logic [223:0] lastP8;

  always #5 clk = ~clk;

  fpmulr2 #(.FPWID(8), .DONE_HOLD(HOLD)) dut8 (
    .i_clk4x(clk), .i_rst_n(rst_n), .i_ld(ld8), .i_a(a8), .i_b(b8),
    .o_p(p8), .o_lzcnt(lz8), .o_busy(busy8), .o_done(done8)
  );

  fpmulr2 #(.FPWID(112), .DONE_HOLD(HOLD)) dut112 (
    .i_clk4x(clk), .i_rst_n(rst_n), .i_ld(ld112), .i_a(a112), .i_b(b112),
    .o_p(p112), .o_lzcnt(lz112), .o_busy(busy112), .o_done(done112)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected ld-to-done latency in edges, from the operand rules alone.
  function automatic int expLatency(input logic [111:0] b, input int w);
`ifdef FPMULR2_EARLY_OUT_EN
    int k;
    k = -1;
    for (int i = 0; i < w; i++) if (b[i]) k = i;
    if (k < 0) return 2;
    if (k < w - 1) return k + 3;
`endif
    return w + 1;
  endfunction

  function automatic int expLz(input logic [223:0] p, input int w);
    int n;
    n = 2 * w;
    for (int i = 0; i < 2 * w; i++) if (p[i]) n = 2 * w - 1 - i;
    return n;
  endfunction

  function automatic logic curDone(input bit big);
    return big ? done112 : done8;
  endfunction

  function automatic logic curBusy(input bit big);
    return big ? busy112 : busy8;
  endfunction

  function automatic logic [223:0] curP(input bit big);
    return big ? p112 : {208'd0, p8};
  endfunction

  function automatic logic [7:0] curLz(input bit big);
    return big ? lz112 : lz8;
  endfunction

  // One complete multiply: load, wait (bounded) for done, compare against the model.
  task automatic applyStimulus(input bit big, input logic [111:0] aIn, input logic [111:0] bIn,
                               input bit checkHold, input string tag);
    int w, lat, hi;
    logic [111:0] a, b;
    logic [223:0] expP;
    w = big ? 112 : 8;
    a = big ? aIn : {104'd0, aIn[7:0]};
    b = big ? bIn : {104'd0, bIn[7:0]};
    expP = 224'(a) * 224'(b);
    @(negedge clk);
    if (big) begin ld112 = 1'b1; a112 = a; b112 = b; end
    else begin ld8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    #1;
    ld8 = 1'b0;
    ld112 = 1'b0;
    checkOutput({tag, "_busy_start"}, 256'(curBusy(big)), 256'(1));
    checkOutput({tag, "_done_cleared"}, 256'(curDone(big)), 256'(0));
    lat = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (curDone(big)) begin lat = i; break; end
    end
    checkOutput({tag, "_latency"}, 256'(lat), 256'(expLatency(b, w)));
    checkOutput({tag, "_p"}, 256'(curP(big)), 256'(expP));
    checkOutput({tag, "_lzcnt"}, 256'(curLz(big)), 256'(expLz(expP, w)));
    checkOutput({tag, "_busy_end"}, 256'(curBusy(big)), 256'(0));
    if (!big) lastP8 = expP;
    if (checkHold) begin
      hi = 1;
      for (int i = 0; i < 300; i++) begin
        @(posedge clk);
        #1;
        if (curDone(big)) hi++;
        else break;
      end
      checkOutput({tag, "_done_width"}, 256'(hi), 256'(HOLD));
      checkOutput({tag, "_p_held"}, 256'(curP(big)), 256'(expP));
    end
  endtask

  initial begin
    int first, rises, sawDone, pStable, busyAll;
    logic prevDone;
    logic [111:0] ra, rb;

    rst_n = 1'b0;
    ld8 = 1'b0; ld112 = 1'b0;
    a8 = '0; b8 = '0; a112 = '0; b112 = '0;
    lastP8 = '0;
    #12;
    checkOutput("reset_p8", 256'(p8), 256'(0));
    checkOutput("reset_lz8", 256'(lz8), 256'(0));
    checkOutput("reset_busy8", 256'(busy8), 256'(0));
    checkOutput("reset_done8", 256'(done8), 256'(0));
    checkOutput("reset_p112", 256'(p112), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 112'hFF, 112'hFF, 1'b1, "ff_x_ff");
    checkOutput("ff_x_ff_const_p", 256'(p8), 256'(16'hFE01));
    applyStimulus(1'b0, 112'h03, 112'h05, 1'b0, "3_x_5");
    checkOutput("3_x_5_const_lz", 256'(lz8), 256'(12));
    applyStimulus(1'b0, 112'h80, 112'h80, 1'b1, "80_x_80");
    checkOutput("80_x_80_const_lz", 256'(lz8), 256'(1));

    // Restart mid-run: only the second operation may complete.
    @(negedge clk);
    ld8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    ld8 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ld8 = 1'b1; a8 = 8'h02; b8 = 8'h03;
    @(posedge clk);
    #1;
    ld8 = 1'b0;
    checkOutput("restart_p_before", 256'(p8), 256'(lastP8));
    first = 0; rises = 0; pStable = 1; prevDone = 1'b0;
    for (int e = 5; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done8 && !prevDone) rises++;
      if (done8 && first == 0) first = e;
      if (first == 0 && p8 !== lastP8[15:0]) pStable = 0;
      prevDone = done8;
    end
    checkOutput("restart_done_edge", 256'(first), 256'(4 + expLatency(112'h3, 8)));
    checkOutput("restart_done_once", 256'(rises), 256'(1));
    checkOutput("restart_old_p_held", 256'(pStable), 256'(1));
    checkOutput("restart_p", 256'(p8), 256'(16'h0006));
    lastP8 = 224'h6;

    applyStimulus(1'b0, 112'h00, 112'hAB, 1'b0, "0_x_ab");
    checkOutput("0_x_ab_const_lz", 256'(lz8), 256'(16));
    applyStimulus(1'b0, 112'hAB, 112'h00, 1'b1, "ab_x_0");
    applyStimulus(1'b0, 112'h11, 112'h01, 1'b0, "11_x_1");
    checkOutput("11_x_1_const_lz", 256'(lz8), 256'(11));

    // ld held high restarts every edge and never completes.
    @(negedge clk);
    ld8 = 1'b1; a8 = 8'h03; b8 = 8'h03;
    sawDone = 0; busyAll = 1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done8) sawDone = 1;
      if (!busy8) busyAll = 0;
    end
    checkOutput("ld_held_no_done", 256'(sawDone), 256'(0));
    checkOutput("ld_held_busy", 256'(busyAll), 256'(1));
    @(negedge clk);
    ld8 = 1'b0;

    // Asynchronous reset in the middle of a run.
    applyStimulus(1'b0, 112'h5A, 112'hC3, 1'b0, "pre_reset");
    @(negedge clk);
    ld8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    ld8 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 256'(busy8), 256'(0));
    checkOutput("midreset_done", 256'(done8), 256'(0));
    checkOutput("midreset_p", 256'(p8), 256'(0));
    checkOutput("midreset_lz", 256'(lz8), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) sawDone = 1;
    end
    checkOutput("midreset_idle_after", 256'(sawDone), 256'(0));

    for (int t = 0; t < 300; t++) begin
      ra = 112'($urandom);
      rb = 112'($urandom);
      if ($urandom_range(0, 9) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) rb = 112'($urandom_range(0, 7));
      applyStimulus(1'b0, ra, rb, 1'b0, "rand8");
    end

    applyStimulus(1'b1, {112{1'b1}}, {112{1'b1}}, 1'b1, "w112_max");
    applyStimulus(1'b1, 112'h1234_5678_9ABC, 112'h0, 1'b0, "w112_b0");
    checkOutput("w112_b0_const_lz", 256'(lz112), 256'(224));
    for (int t = 0; t < 15; t++) begin
      ra = {$urandom, $urandom, $urandom, $urandom} >> ($urandom_range(0, 100));
      rb = {$urandom, $urandom, $urandom, $urandom} >> ($urandom_range(0, 100));
      applyStimulus(1'b1, ra, rb, 1'b0, "rand112");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
